// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory boot
//                loader (state encoding, default depth, word geometry).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

   // Default instruction memory size in 32-bit words; also the largest image.
   localparam int DEPTH_DEFAULT = 64;

   // Bytes per instruction word.
   localparam int WORD_BYTES = 4;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5,
      S_ERR   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_assembler
//  Description : Collects bytes into a little-endian 32-bit word. The first
//                byte of a word lands in bits [7:0]. Only the three pending
//                bytes are stored; the completing byte is merged on the fly so
//                the full word is available in the same cycle it is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_clear,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_next,
   output logic        o_word_full
);

   localparam int CNT_W  = $clog2(WORD_BYTES);
   localparam int PEND_W = (WORD_BYTES - 1) * 8;

   logic [CNT_W-1:0]  r_cnt;
   logic [PEND_W-1:0] r_pend;

   // Word as it stands once the incoming byte is included (valid on 4th byte).
   assign o_word_next = {i_byte, r_pend};
   assign o_word_full = i_en && (r_cnt == CNT_W'(WORD_BYTES - 1));

   // Byte position counter and pending-byte shift register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_pend <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_pend <= '0;
      end else if (i_en) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_pend <= {i_byte, r_pend[PEND_W-1:8]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction memory writer. Receives a 2-byte
//                little-endian length header followed by instruction words
//                over valid/ready, writes each word to the instruction RAM and
//                holds the core in reset until the image is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int LEN_W = 16
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        we,
   output logic [31:0] wa,
   output logic [31:0] wd,
   output logic        cpu_hold,
   output logic        done,
   output logic        err
);

   state_t            r_state;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_word_idx;
   logic              r_we;
   logic [31:0]       r_wa;
   logic [31:0]       r_wd;
   logic              r_cpu_hold;
   logic              r_done;
   logic              r_err;

   logic              w_xfer;
   logic              w_asm_en;
   logic              w_asm_clear;
   logic [31:0]       w_word_next;
   logic              w_word_full;
   logic [LEN_W-1:0]  w_len_full;
   logic [LEN_W-1:0]  w_idx_inc;

   // Ready depends on state alone so the source never sees a valid->ready loop.
   assign in_ready    = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
   assign w_xfer      = in_valid && in_ready;
   assign w_asm_en    = w_xfer && (r_state == S_DATA);
   // Outside DATA the assembler is kept empty so every word starts at byte 0.
   assign w_asm_clear = (r_state != S_DATA);
   assign w_len_full  = LEN_W'({in_data, r_len[7:0]});
   assign w_idx_inc   = r_word_idx + LEN_W'(1);

   assign we       = r_we;
   assign wa       = r_wa;
   assign wd       = r_wd;
   assign cpu_hold = r_cpu_hold;
   assign done     = r_done;
   assign err      = r_err;

   byte_assembler u_asm (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clear     (w_asm_clear),
      .i_en        (w_asm_en),
      .i_byte      (in_data),
      .o_word_next (w_word_next),
      .o_word_full (w_word_full)
   );

   // Load sequencer with registered write port and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_word_idx <= '0;
         r_we       <= 1'b0;
         r_wa       <= '0;
         r_wd       <= '0;
         r_cpu_hold <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) r_state <= S_LEN0;
            end
            S_LEN0: begin
               if (w_xfer) begin
                  r_len   <= LEN_W'(in_data);
                  r_state <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_xfer) begin
                  r_len      <= w_len_full;
                  r_word_idx <= '0;
                  if (w_len_full == '0) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else if (w_len_full > LEN_W'(DEPTH)) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // Write strobe, address and data are captured together so the
               // write port is fully registered during WRITE.
               if (w_word_full) begin
                  r_state <= S_WRITE;
                  r_we    <= 1'b1;
                  r_wa    <= 32'({r_word_idx, 2'b00});
                  r_wd    <= w_word_next;
               end
            end
            S_WRITE: begin
               r_word_idx <= w_idx_inc;
               if (w_idx_inc == r_len) begin
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
                  r_cpu_hold <= 1'b0;
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_DONE, S_ERR: begin
               if (start) begin
                  r_state    <= S_LEN0;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_cpu_hold <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Images are built as byte
//                lists; expected writes are derived directly from the byte
//                list (word k = little-endian bytes 2+4k..5+4k at address 4k).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

   localparam int DEPTH = 64;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        we;
   logic [31:0] wa;
   logic [31:0] wd;
   logic        cpu_hold;
   logic        done;
   logic        err;

   int vectors;
   int miscompares;
   int cyc;
   int last_we_cyc;

   logic [7:0]  img[$];
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   imem_loader #(.DEPTH(DEPTH), .LEN_W(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: records every cycle with we high.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (we === 1'b1) begin
         wa_q.push_back(wa);
         wd_q.push_back(wd);
         last_we_cyc = cyc;
      end
   end

   // ---------------- reference model ----------------
   function automatic int img_len();
      return int'({img[1], img[0]});
   endfunction

   function automatic logic [31:0] exp_wd(input int k);
      int b;
      b = 2 + 4 * k;
      return {img[b + 3], img[b + 2], img[b + 1], img[b]};
   endfunction

   task automatic make_image(input int len);
      img.delete();
      img.push_back(len[7:0]);
      img.push_back(len[15:8]);
      if (len <= DEPTH)
         for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke, input bit chk_gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk); start = 1'b0; in_valid = 1'b0;
         if (chk_gap) begin
            vectors++;
            if (in_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL ready_in_gap: in_ready=%b required 1", in_ready);
            end
         end
      end
      @(negedge clk); start = poke; in_valid = 1'b1; in_data = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk); start = 1'b0; n++;
      end
      vectors++;
      if (n >= 100) begin
         miscompares++;
         $display("FAIL byte_accept_timeout: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic load_image(input int gap_max, input bit poke);
      for (int i = 0; i < img.size(); i++)
         send_byte(img[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0,
                   poke && (i >= 2) && ($urandom_range(0, 3) == 0), 1'b0);
      @(negedge clk); in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic wait_end(output int n);
      n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (done !== 1'b1 && err !== 1'b1 && n < 2000);
      vectors++;
      if (n >= 2000) begin
         miscompares++;
         $display("FAIL end_timeout: done=%b err=%b required one of them 1", done, err);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'hAA;
      repeat (3) @(negedge clk);
      vectors++;
      if ({in_ready, we, cpu_hold, done, err} !== 5'b00100 || wa !== 32'h0 || wd !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_state: rdy/we/hold/done/err=%b wa=%h wd=%h required 00100 0 0",
                  {in_ready, we, cpu_hold, done, err}, wa, wd);
      end
      @(negedge clk); reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({in_ready, we, cpu_hold, done} !== 4'b0010) begin
            miscompares++;
            $display("FAIL idle_before_start: rdy/we/hold/done=%b required 0010",
                     {in_ready, we, cpu_hold, done});
         end
      end
      in_valid = 1'b0;
      vectors++;
      if (wa_q.size() != 0) begin
         miscompares++;
         $display("FAIL idle_no_writes: writes=%0d required 0", wa_q.size());
      end
   endtask

   task automatic test_basic();
      int n;
      img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      load_image(0, 1'b0);
      wait_end(n);
      vectors++;
      if (wa_q.size() != 2 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00000513 ||
          wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00100593) begin
         miscompares++;
         $display("FAIL basic_writes: n=%0d wa0=%h wd0=%h wa1=%h wd1=%h required 2 0 00000513 4 00100593",
                  wa_q.size(), wa_q.size() > 0 ? wa_q[0] : 0, wd_q.size() > 0 ? wd_q[0] : 0,
                  wa_q.size() > 1 ? wa_q[1] : 0, wd_q.size() > 1 ? wd_q[1] : 0);
      end
      vectors++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0 || cyc != last_we_cyc + 1) begin
         miscompares++;
         $display("FAIL basic_done: done=%b hold=%b err=%b cyc_after_write=%0d required 1 0 0 1",
                  done, cpu_hold, err, cyc - last_we_cyc);
      end
   endtask

   task automatic test_stall();
      int n;
      img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      vectors++;
      if (cpu_hold !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL restart_from_done: hold=%b done=%b required 1 0", cpu_hold, done);
      end
      for (int i = 0; i < img.size(); i++)
         send_byte(img[i], (i == 4) ? 3 : 0, 1'b0, i == 4);
      @(negedge clk); in_valid = 1'b0;
      wait_end(n);
      vectors++;
      if (wa_q.size() != 2 || wd_q[0] !== 32'h00000513 || wd_q[1] !== 32'h00100593 ||
          wa_q[0] !== 32'h0 || wa_q[1] !== 32'h4 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_writes: n=%0d done=%b required 2 writes identical to basic, done 1",
                  wa_q.size(), done);
      end
   endtask

   task automatic test_zero_len();
      int n;
      img = '{8'h00, 8'h00};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      load_image(0, 1'b0);
      wait_end(n);
      vectors++;
      if (wa_q.size() != 0 || done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_len: writes=%0d done=%b hold=%b err=%b required 0 1 0 0",
                  wa_q.size(), done, cpu_hold, err);
      end
   endtask

   task automatic test_err();
      int n;
      int len;
      for (int t = 0; t < 4; t++) begin
         len = (t == 0) ? DEPTH + 1 : int'($urandom_range(DEPTH + 1, 65535));
         make_image(len);
         wa_q.delete(); wd_q.delete();
         pulse_start();
         load_image(1, 1'b0);
         repeat (3) @(negedge clk);
         #1;
         vectors++;
         if (err !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || wa_q.size() != 0) begin
            miscompares++;
            $display("FAIL err_len_%0d: err=%b hold=%b rdy=%b done=%b writes=%0d required 1 1 0 0 0",
                     len, err, cpu_hold, in_ready, done, wa_q.size());
         end
      end
      // Restart out of ERR must clear err and reopen the byte stream.
      pulse_start();
      vectors++;
      if (err !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL err_restart: err=%b hold=%b rdy=%b required 0 1 1", err, cpu_hold, in_ready);
      end
      make_image(1);
      load_image(0, 1'b0);
      wait_end(n);
      vectors++;
      if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== exp_wd(0) || done !== 1'b1) begin
         miscompares++;
         $display("FAIL err_reload: writes=%0d done=%b required 1 1", wa_q.size(), done);
      end
   endtask

   task automatic test_random_images(input int count, input bit poke);
      int n;
      int len;
      int bad;
      for (int t = 0; t < count; t++) begin
         len = int'($urandom_range(1, 8));
         make_image(len);
         wa_q.delete(); wd_q.delete();
         pulse_start();
         load_image(2, poke);
         wait_end(n);
         bad = 0;
         if (wa_q.size() != img_len()) bad = 1;
         else
            for (int k = 0; k < img_len(); k++)
               if (wa_q[k] !== 32'(4 * k) || wd_q[k] !== exp_wd(k)) bad = 1;
         vectors++;
         if (bad != 0 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL random_image_len_%0d: writes=%0d done=%b hold=%b required %0d matching writes, 1 0",
                     len, wa_q.size(), done, cpu_hold, img_len());
         end
      end
   endtask

   task automatic test_full_depth();
      int n;
      int bad;
      make_image(DEPTH);
      wa_q.delete(); wd_q.delete();
      pulse_start();
      load_image(0, 1'b0);
      wait_end(n);
      bad = 0;
      if (wa_q.size() != DEPTH) bad = 1;
      else
         for (int k = 0; k < DEPTH; k++)
            if (wa_q[k] !== 32'(4 * k) || wd_q[k] !== exp_wd(k)) bad = 1;
      vectors++;
      if (bad != 0 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL full_depth: writes=%0d done=%b required %0d 1", wa_q.size(), done, DEPTH);
      end
      vectors++;
      if (wa_q.size() == 0 || wa_q[wa_q.size() - 1] !== 32'hFC) begin
         miscompares++;
         $display("FAIL full_depth_last_wa: wa=%h required 000000fc",
                  wa_q.size() > 0 ? wa_q[wa_q.size() - 1] : 32'hx);
      end
   endtask

   task automatic test_reset_mid_load();
      make_image(2);
      wa_q.delete(); wd_q.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(img[i], 0, 1'b0, 1'b0);
      @(negedge clk); in_valid = 1'b0; reset_n = 1'b0;
      #1;
      vectors++;
      if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || we !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_state: hold=%b rdy=%b we=%b done=%b required 1 0 0 0",
                  cpu_hold, in_ready, we, done);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (wa_q.size() != 1 || wd_q[0] !== exp_wd(0) || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_writes: writes=%0d rdy=%b required 1 0", wa_q.size(), in_ready);
      end
      test_random_images(3, 1'b1);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; last_we_cyc = 0;
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_err();
      test_random_images(6, 1'b0);
      test_full_depth();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
